// File: rtl/r2r_sar_adc.sv
// MSB-first successive-approximation controller for an 8-bit R2R ladder ADC.
// Each trial code settles for SETTLE_CYCLES clocks before the synchronized comparator decides its bit.
module r2r_sar_adc #(
    parameter int SETTLE_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       comp_in,
    output logic [7:0] r2r_out,
    output logic [7:0] raw_data,
    output logic       sample_valid,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DECIDE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] sar_q, sar_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [9:0] cnt_q, cnt_d;
    logic [7:0] r2r_q, r2r_d;
    logic [7:0] raw_q, raw_d;
    logic       valid_q, valid_d;
    logic       sync1_q, comp_s_q;
    logic [7:0] sar_dec;

    always_comb begin
        state_d   = state_q;
        sar_d     = sar_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        r2r_d     = r2r_q;
        raw_d     = raw_q;
        valid_d   = 1'b0;

        // Trial bit survives only if Vin >= Vladder for the current code
        sar_dec = sar_q;
        if (!comp_s_q) begin
            sar_dec[bit_idx_q] = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    sar_d     = 8'h80;
                    r2r_d     = 8'h80;
                    bit_idx_d = 3'd7;
                    cnt_d     = 10'd0;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_DECIDE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_DECIDE: begin
                if (bit_idx_q != 3'd0) begin
                    sar_d     = sar_dec | (8'h01 << (bit_idx_q - 3'd1));
                    r2r_d     = sar_d;
                    bit_idx_d = bit_idx_q - 3'd1;
                    cnt_d     = 10'd0;
                    state_d   = ST_SETTLE;
                end else begin
                    sar_d   = sar_dec;
                    raw_d   = sar_dec;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sar_q     <= 8'h00;
            bit_idx_q <= 3'd0;
            cnt_q     <= 10'd0;
            r2r_q     <= 8'h00;
            raw_q     <= 8'h00;
            valid_q   <= 1'b0;
            sync1_q   <= 1'b0;
            comp_s_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sar_q     <= sar_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            r2r_q     <= r2r_d;
            raw_q     <= raw_d;
            valid_q   <= valid_d;
            sync1_q   <= comp_in;
            comp_s_q  <= sync1_q;
        end
    end

    assign r2r_out      = r2r_q;
    assign raw_data     = raw_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_r2r_sar_adc.sv
// Directed bench for r2r_sar_adc with SETTLE_CYCLES=4 (42-cycle conversion period).
module tb_r2r_sar_adc;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       comp_in;
    logic [7:0] r2r_out;
    logic [7:0] raw_data;
    logic       sample_valid;
    logic       busy;

    logic       use_model = 1'b0;
    logic       comp_fixed = 1'b0;
    logic [7:0] vin = 8'h00;

    int checks = 0;
    int failures = 0;

    // Comparator model: either a fixed level or an ideal Vin >= Vladder comparison
    assign comp_in = use_model ? (vin >= r2r_out) : comp_fixed;

    r2r_sar_adc #(.SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .comp_in      (comp_in),
        .r2r_out      (r2r_out),
        .raw_data     (raw_data),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns the number of ticks until sample_valid is seen, 0 if never within limit
    task automatic wait_valid(input int limit, output int cycles);
        int i;
        cycles = 0;
        i = 0;
        while (i < limit && cycles == 0) begin
            tick();
            i++;
            if (sample_valid === 1'b1) cycles = i;
        end
    endtask

    task automatic test_reset;
        int bad;
        reset = 1'b1;
        use_model = 1'b0;
        for (int i = 0; i < 3; i++) begin
            comp_fixed = ~comp_fixed;
            tick();
        end
        checks++; if (r2r_out !== 8'h00) begin failures++; $display("FAIL reset_r2r got %h exp 00", r2r_out); end
        checks++; if (raw_data !== 8'h00) begin failures++; $display("FAIL reset_raw got %h exp 00", raw_data); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            comp_fixed = ~comp_fixed;
            tick();
            if (busy !== 1'b0 || sample_valid !== 1'b0 || r2r_out !== 8'h00) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL idle_quiet got %0d active cycles exp 0", bad); end
        comp_fixed = 1'b0;
    endtask

    task automatic run_fixed(input logic level, input logic [7:0] expv);
        use_model = 1'b0;
        comp_fixed = level;
        en = 1'b1;
        tick();
        en = 1'b0;
        repeat (39) tick();
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL fixed_early_valid got %b exp 0", sample_valid); end
        tick();
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL fixed_valid_edge40 got %b exp 1", sample_valid); end
        checks++; if (raw_data !== expv) begin failures++; $display("FAIL fixed_raw got %h exp %h", raw_data, expv); end
        tick();
        checks++; if (sample_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL fixed_after got valid=%b busy=%b exp 0 0", sample_valid, busy);
        end
    endtask

    task automatic test_fixed_comparator;
        run_fixed(1'b1, 8'hFF);
        run_fixed(1'b0, 8'h00);
    endtask

    task automatic test_behavioural;
        logic [7:0] seq [8];
        seq = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
        use_model = 1'b1;
        vin = 8'h5A;
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) repeat (S + 1) tick();
            checks++; if (r2r_out !== seq[k]) begin failures++; $display("FAIL trial_code_%0d got %h exp %h", k, r2r_out, seq[k]); end
        end
        repeat (S + 1) tick();
        checks++; if (sample_valid !== 1'b1 || raw_data !== 8'h5A) begin
            failures++; $display("FAIL behav_result got valid=%b raw=%h exp 1 5a", sample_valid, raw_data);
        end
        tick();
        checks++; if (r2r_out !== 8'h5B || busy !== 1'b0) begin
            failures++; $display("FAIL behav_hold got r2r=%h busy=%b exp 5b 0", r2r_out, busy);
        end
    endtask

    task automatic test_free_run;
        int c;
        int idle_bad;
        use_model = 1'b1;
        vin = 8'h5A;
        en = 1'b1;
        wait_valid(100, c);
        checks++; if (c != 41) begin failures++; $display("FAIL freerun_first got %0d exp 41", c); end
        checks++; if (raw_data !== 8'h5A) begin failures++; $display("FAIL freerun_raw0 got %h exp 5a", raw_data); end
        vin = 8'hA3;
        for (int p = 0; p < 2; p++) begin
            tick();
            checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL freerun_width_%0d got %b exp 0", p, sample_valid); end
            wait_valid(100, c);
            checks++; if (c + 1 != 42) begin failures++; $display("FAIL freerun_period_%0d got %0d exp 42", p, c + 1); end
            checks++; if (raw_data !== 8'hA3) begin failures++; $display("FAIL freerun_raw_%0d got %h exp a3", p, raw_data); end
        end
        en = 1'b0;
        tick();
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b0) idle_bad++;
            tick();
        end
        checks++; if (idle_bad != 0) begin failures++; $display("FAIL freerun_stop got %0d busy cycles exp 0", idle_bad); end
    endtask

    task automatic test_en_handling;
        int c;
        int nvalid;
        int busy_bad;
        use_model = 1'b1;
        vin = 8'h21;
        en = 1'b1;
        tick();
        en = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sample_valid === 1'b1) nvalid++;
        end
        checks++; if (nvalid != 1) begin failures++; $display("FAIL en_pulse_count got %0d exp 1", nvalid); end
        checks++; if (raw_data !== 8'h21) begin failures++; $display("FAIL en_pulse_raw got %h exp 21", raw_data); end

        vin = 8'hC4;
        en = 1'b1;
        tick();
        repeat (2 * (S + 1)) tick();
        en = 1'b0;
        wait_valid(60, c);
        checks++; if (c != 30) begin failures++; $display("FAIL en_drop_latency got %0d exp 30", c); end
        checks++; if (raw_data !== 8'hC4) begin failures++; $display("FAIL en_drop_raw got %h exp c4", raw_data); end
        tick();
        nvalid = 0;
        busy_bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (busy !== 1'b0) busy_bad++;
            tick();
            if (sample_valid === 1'b1) nvalid++;
        end
        checks++; if (nvalid != 0 || busy_bad != 0) begin
            failures++; $display("FAIL en_drop_idle got valids=%0d busy_cycles=%0d exp 0 0", nvalid, busy_bad);
        end
    endtask

    task automatic test_reset_mid_conversion;
        int c;
        int nvalid;
        use_model = 1'b1;
        vin = 8'h3C;
        en = 1'b1;
        tick();
        en = 1'b0;
        // After edge 24 the FSM sits in DECIDE for bit 3
        repeat (4 * (S + 1) + S) tick();
        reset = 1'b1;
        tick();
        checks++; if (r2r_out !== 8'h00 || raw_data !== 8'h00) begin
            failures++; $display("FAIL midreset_data got r2r=%h raw=%h exp 00 00", r2r_out, raw_data);
        end
        checks++; if (sample_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midreset_ctrl got valid=%b busy=%b exp 0 0", sample_valid, busy);
        end
        repeat (2) tick();
        reset = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (sample_valid === 1'b1) nvalid++;
        end
        checks++; if (nvalid != 0) begin failures++; $display("FAIL midreset_novalid got %0d exp 0", nvalid); end
        vin = 8'h37;
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++; if (r2r_out !== 8'h80) begin failures++; $display("FAIL midreset_restart got %h exp 80", r2r_out); end
        wait_valid(60, c);
        checks++; if (c != 40) begin failures++; $display("FAIL midreset_latency got %0d exp 40", c); end
        checks++; if (raw_data !== 8'h37) begin failures++; $display("FAIL midreset_raw got %h exp 37", raw_data); end
    endtask

    initial begin
        test_reset();
        test_fixed_comparator();
        test_behavioural();
        test_free_run();
        test_en_handling();
        test_reset_mid_conversion();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/r2r_sar_adc.md
# r2r_sar_adc

Successive-approximation controller for the 8-bit R2R ADC front end. It drives the R2R ladder code, samples the external analog comparator after a programmable settle time, and resolves one 8-bit sample MSB-first. Each completed sample is presented on `raw_data` with a one-cycle `sample_valid` strobe. That strobe directly drives the enable of the downstream R2R averaging/scaling subsystem.

## Interface
- `SETTLE_CYCLES`, default 64: clock cycles each trial code is held on the ladder before the comparator decision. Legal range is 3..1023; the settle counter is 10 bits.
- `clk`  input  1  system clock
- `reset`  input  1  synchronous, active-high reset
- `en`  input  1  conversion request, sampled only in IDLE; held high gives free-running conversions
- `comp_in`  input  1  asynchronous comparator output; 1 means Vin >= Vladder
- `r2r_out`  output  8  trial code driven to the R2R ladder
- `raw_data`  output  8  last completed conversion result
- `sample_valid`  output  1  one-cycle pulse when `raw_data` updates
- `busy`  output  1  high whenever the FSM is not in IDLE

## Operation
- Synchronizer: `comp_in` passes through a 2-flop synchronizer. Decisions use only the second flop (`comp_s`).
- Internal registers: `sar[7:0]` holds the result under construction; `bit_idx[2:0]` is the bit under test; `cnt[9:0]` is the settle counter.
- FSM states are IDLE, SETTLE, DECIDE, DONE.
- IDLE with `en`=1:
  - set `sar`=0x80, `r2r_out`=0x80, `bit_idx`=7, `cnt`=0;
  - go to SETTLE.
- IDLE with `en`=0: stay in IDLE; all registers hold.
- SETTLE:
  - if `cnt`==SETTLE_CYCLES-1, go to DECIDE;
  - otherwise increment `cnt`.
  - `r2r_out` is stable throughout.
- DECIDE:
  - if `comp_s`=0, clear `sar[bit_idx]`; if `comp_s`=1, keep it.
  - If `bit_idx`>0: set `sar[bit_idx-1]`, drive `r2r_out` with the updated `sar`, decrement `bit_idx`, clear `cnt`, go to SETTLE.
  - If `bit_idx`==0: `raw_data` takes the final `sar`, `sample_valid` goes to 1, go to DONE.
- DONE:
  - `sample_valid` returns to 0 on exit;
  - go to IDLE unconditionally.
- `en` is ignored outside IDLE. Dropping `en` mid-conversion does not abort the conversion.
- `r2r_out` holds the last trial code while in DONE and IDLE.
- `raw_data` holds its value until the next conversion completes.
- Reset values: `r2r_out`=0x00, `raw_data`=0x00, `sample_valid`=0, `busy`=0, FSM=IDLE, `sar`=0, `cnt`=0, synchronizer flops=0.
- Reset asserted mid-conversion:
  - the next edge forces all reset values;
  - no `sample_valid` is produced for the partial conversion.
- Comparator edge cases: `comp_in` constantly 1 gives 0xFF; constantly 0 gives 0x00.

## Timing
- Edge 0 is the edge that samples `en`=1 in IDLE. `r2r_out`=0x80 after edge 0.
- Each bit takes SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in SETTLE plus 1 in DECIDE.
- `r2r_out` changes only on the DECIDE edge and on the IDLE-start edge.
- `sample_valid` is high for exactly the cycle after edge 8*(SETTLE_CYCLES+1), then low.
- `raw_data` is valid from that same cycle onward.
- With `en` held high, the next start edge is 8*(SETTLE_CYCLES+1)+2. The conversion period is 8*SETTLE_CYCLES+10 cycles; at the default this is 522.
- The synchronizer adds 2 cycles of latency. SETTLE_CYCLES >= 3 guarantees `comp_s` reflects the current trial code at DECIDE.
- `busy` goes high after edge 0 and low after the DONE-exit edge. It is low in the cycle where `sample_valid` has just fallen.

## Test plan
- Reset: assert `reset` for 3 cycles with `comp_in` toggling. Require `r2r_out`=0x00, `raw_data`=0x00, `sample_valid`=0, `busy`=0, and no activity while `en`=0.
- Fixed comparator (SETTLE_CYCLES=4): hold `comp_in`=1, pulse `en`. Require `raw_data`=0xFF with `sample_valid` after edge 40. Repeat with `comp_in`=0; require `raw_data`=0x00.
- Behavioural comparator (`comp_in` = 0x5A >= `r2r_out`): require the `r2r_out` sequence 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A, 0x5B, and final `raw_data`=0x5A.
- Free-run (SETTLE_CYCLES=4, `en` held high): require `sample_valid` pulses exactly 42 cycles apart, each exactly 1 cycle wide. Step the comparator model's Vin to 0xA3 mid-run; the next completed sample must be 0xA3.
- `en` handling: a 1-cycle `en` pulse produces exactly one conversion. Dropping `en` at bit 5 still completes that conversion; afterwards the FSM stays in IDLE with `busy`=0.
- Reset mid-conversion: assert `reset` during DECIDE of bit 3. Require all outputs at reset values on the next edge and no `sample_valid`. A fresh `en` afterwards converts correctly from 0x80.
